// File: rtl/branch_predictor.sv
// Fetch-side branch direction predictor: a PC-indexed table of 2-bit saturating
// counters read in F, trained when the decode-stage comparator resolves a branch.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pcF,
  input  logic             stallD,
  input  logic             flushD,
  input  logic             branchF,
  input  logic [31:0]      pcD,
  input  logic             branchD,
  input  logic             actual_takenD,
  output logic             pred_takenF,
  output logic             pred_takenD,
  output logic             mispredictD,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            ctr_q [ENTRIES];
  logic [INDEX_BITS-1:0] idx_f;
  logic [INDEX_BITS-1:0] idx_d;
  logic [1:0]            ctr_old;
  logic [1:0]            ctr_new;
  logic                  upd;
  logic                  pred_q, pred_d;
  logic                  valid_q, valid_d;
  logic [CNT_W-1:0]      bcnt_q, bcnt_d;
  logic [CNT_W-1:0]      mcnt_q, mcnt_d;
  logic                  unused_pc_bits;

  assign idx_f = pcF[INDEX_BITS+1:2];
  assign idx_d = pcD[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{pcF[31:INDEX_BITS+2], pcF[1:0], pcD[31:INDEX_BITS+2], pcD[1:0]};

  // No write-to-read bypass: F sees the pre-update entry in a collision cycle.
  assign pred_takenF = branchF & ctr_q[idx_f][1];
  assign pred_takenD = pred_q & valid_q;
  assign upd         = branchD & ~stallD;
  assign mispredictD = upd & (pred_takenD ^ actual_takenD);

  assign branch_cnt     = bcnt_q;
  assign mispredict_cnt = mcnt_q;

  always_comb begin
    ctr_old = ctr_q[idx_d];
    ctr_new = ctr_old;
    if (actual_takenD) begin
      if (ctr_old != 2'b11) ctr_new = ctr_old + 2'b01;
    end else begin
      if (ctr_old != 2'b00) ctr_new = ctr_old - 2'b01;
    end
  end

  always_comb begin
    pred_d = pred_q;
    valid_d = valid_q;
    if (flushD) begin
      pred_d  = 1'b0;
      valid_d = 1'b0;
    end else if (!stallD) begin
      pred_d  = pred_takenF;
      valid_d = branchF;
    end
  end

  always_comb begin
    bcnt_d = bcnt_q + {{(CNT_W-1){1'b0}}, upd};
    mcnt_d = mcnt_q + {{(CNT_W-1){1'b0}}, mispredictD};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (upd) begin
      ctr_q[idx_d] <= ctr_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_q  <= 1'b0;
      valid_q <= 1'b0;
      bcnt_q  <= '0;
      mcnt_q  <= '0;
    end else begin
      pred_q  <= pred_d;
      valid_q <= valid_d;
      bcnt_q  <= bcnt_d;
      mcnt_q  <= mcnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random
// traffic compared against a behavioural table/counter model.
module tb_branch_predictor;

  localparam int IB = 6;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   pcF = '0;
  logic          stallD = 1'b0;
  logic          flushD = 1'b0;
  logic          branchF = 1'b0;
  logic [31:0]   pcD = '0;
  logic          branchD = 1'b0;
  logic          actual_takenD = 1'b0;
  logic          pred_takenF;
  logic          pred_takenD;
  logic          mispredictD;
  logic [CW-1:0] branch_cnt;
  logic [CW-1:0] mispredict_cnt;

  int vectors = 0;
  int miscompares = 0;

  int mctr [64];
  bit m_pred;
  int m_bcnt;
  int m_mcnt;

  branch_predictor #(.INDEX_BITS(IB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .pcF(pcF), .stallD(stallD), .flushD(flushD),
    .branchF(branchF), .pcD(pcD), .branchD(branchD), .actual_takenD(actual_takenD),
    .pred_takenF(pred_takenF), .pred_takenD(pred_takenD), .mispredictD(mispredictD),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function bit m_predF();
    return branchF && (mctr[idx_of(pcF)] >= 2);
  endfunction

  function bit m_misp();
    return branchD && !stallD && (m_pred != actual_takenD);
  endfunction

  function void m_reset();
    foreach (mctr[i]) mctr[i] = 1;
    m_pred = 0;
    m_bcnt = 0;
    m_mcnt = 0;
  endfunction

  function void model_edge();
    bit pf, mp;
    int i;
    if (rst) begin
      m_reset();
      return;
    end
    pf = m_predF();
    mp = m_misp();
    if (branchD && !stallD) begin
      i = idx_of(pcD);
      if (actual_takenD) mctr[i] = (mctr[i] == 3) ? 3 : mctr[i] + 1;
      else               mctr[i] = (mctr[i] == 0) ? 0 : mctr[i] - 1;
      m_bcnt = (m_bcnt + 1) % 16;
      m_mcnt = (m_mcnt + (mp ? 1 : 0)) % 16;
    end
    if (flushD)       m_pred = 0;
    else if (!stallD) m_pred = pf;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [31:0] fpc, input logic fb, input logic [31:0] dpc,
                       input logic db, input logic act, input logic st, input logic fl);
    pcF = fpc; branchF = fb; pcD = dpc; branchD = db;
    actual_takenD = act; stallD = st; flushD = fl;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_reset();
    drive(32'h0040_0010, 1, 32'h0, 0, 0, 0, 0);
    vectors++;
    if (pred_takenF !== 1'b0) begin miscompares++; $display("FAIL reset_predF got=%b exp=0", pred_takenF); end
    vectors++;
    if (pred_takenD !== 1'b0) begin miscompares++; $display("FAIL reset_predD got=%b exp=0", pred_takenD); end
    tick();
    rst = 1'b0;
    drive(32'h0040_0010, 0, 32'h0, 0, 0, 0, 0);
    vectors++;
    if (pred_takenF !== 1'b0) begin miscompares++; $display("FAIL reset_nonbranch got=%b exp=0", pred_takenF); end
    vectors++;
    if (branch_cnt !== 4'd0 || mispredict_cnt !== 4'd0) begin
      miscompares++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", branch_cnt, mispredict_cnt);
    end
    tick();
  endtask

  // Each branch is fetched one cycle and resolved the next, with a bubble between.
  task automatic test_train();
    for (int k = 0; k < 3; k++) begin
      drive(32'h0040_0010, 1, 32'h0, 0, 0, 0, 0);
      vectors++;
      if (pred_takenF !== (k > 0)) begin
        miscompares++; $display("FAIL train_predF[%0d] got=%b exp=%b", k, pred_takenF, k > 0);
      end
      tick();
      drive(32'h0, 0, 32'h0040_0010, 1, 1, 0, 0);
      vectors++;
      if (mispredictD !== (k == 0)) begin
        miscompares++; $display("FAIL train_misp[%0d] got=%b exp=%b", k, mispredictD, k == 0);
      end
      tick();
    end
    drive(32'h0, 0, 32'h0, 0, 0, 0, 0);
    vectors++;
    if (branch_cnt !== 4'd3 || mispredict_cnt !== 4'd1) begin
      miscompares++; $display("FAIL train_counts got=%0d/%0d exp=3/1", branch_cnt, mispredict_cnt);
    end
  endtask

  task automatic test_hysteresis();
    for (int k = 0; k < 2; k++) begin
      drive(32'h0040_0010, 1, 32'h0, 0, 0, 0, 0);
      vectors++;
      if (pred_takenF !== 1'b1) begin
        miscompares++; $display("FAIL hyst_predF[%0d] got=%b exp=1", k, pred_takenF);
      end
      tick();
      drive(32'h0, 0, 32'h0040_0010, 1, 0, 0, 0);
      vectors++;
      if (mispredictD !== 1'b1) begin
        miscompares++; $display("FAIL hyst_misp[%0d] got=%b exp=1", k, mispredictD);
      end
      tick();
    end
    drive(32'h0040_0010, 1, 32'h0, 0, 0, 0, 0);
    vectors++;
    if (pred_takenF !== 1'b0) begin miscompares++; $display("FAIL hyst_final got=%b exp=0", pred_takenF); end
    tick();
  endtask

  task automatic test_stall_flush();
    int b0, m0;
    b0 = m_bcnt; m0 = m_mcnt;
    for (int k = 0; k < 3; k++) begin
      drive(32'h0040_0030, 1, 32'h0040_0030, 1, 1, 1, 0);
      vectors++;
      if (mispredictD !== 1'b0) begin miscompares++; $display("FAIL stall_misp[%0d] got=%b exp=0", k, mispredictD); end
      tick();
    end
    drive(32'h0040_0030, 1, 32'h0, 0, 0, 0, 0);
    vectors++;
    if (pred_takenF !== 1'b0 || 32'(branch_cnt) !== b0 || 32'(mispredict_cnt) !== m0) begin
      miscompares++;
      $display("FAIL stall_hold got=%b/%0d/%0d exp=0/%0d/%0d", pred_takenF, branch_cnt, mispredict_cnt, b0, m0);
    end
    drive(32'h0, 0, 32'h0040_0030, 1, 1, 0, 0);
    tick();
    drive(32'h0040_0030, 1, 32'h0, 0, 0, 0, 0);
    vectors++;
    if (pred_takenF !== 1'b1 || 32'(branch_cnt) !== (b0 + 1) % 16) begin
      miscompares++; $display("FAIL stall_release got=%b/%0d exp=1/%0d", pred_takenF, branch_cnt, (b0 + 1) % 16);
    end
    tick();
    drive(32'h0040_0030, 1, 32'h0, 0, 0, 1, 1);
    vectors++;
    if (pred_takenD !== 1'b1) begin miscompares++; $display("FAIL flush_pre got=%b exp=1", pred_takenD); end
    tick();
    drive(32'h0, 0, 32'h0, 0, 0, 0, 0);
    vectors++;
    if (pred_takenD !== 1'b0) begin miscompares++; $display("FAIL flush_over_stall got=%b exp=0", pred_takenD); end
    tick();
  endtask

  task automatic test_collision();
    drive(32'h0040_0020, 1, 32'h0040_0020, 1, 1, 0, 0);
    vectors++;
    if (pred_takenF !== 1'b0) begin miscompares++; $display("FAIL collide_same got=%b exp=0", pred_takenF); end
    tick();
    drive(32'h0040_0020, 1, 32'h0, 0, 0, 0, 0);
    vectors++;
    if (pred_takenF !== 1'b1) begin miscompares++; $display("FAIL collide_next got=%b exp=1", pred_takenF); end
    tick();
  endtask

  task automatic test_alias_wrap();
    int b0;
    drive(32'h0040_0104, 1, 32'h0040_0004, 1, 1, 0, 0);
    vectors++;
    if (pred_takenF !== 1'b0) begin miscompares++; $display("FAIL alias_pre got=%b exp=0", pred_takenF); end
    tick();
    drive(32'h0040_0104, 1, 32'h0, 0, 0, 0, 0);
    vectors++;
    if (pred_takenF !== 1'b1) begin miscompares++; $display("FAIL alias_post got=%b exp=1", pred_takenF); end
    tick();
    b0 = m_bcnt;
    for (int k = 0; k < 16; k++) begin
      drive(32'h0, 0, 32'h0040_0000 + 32'($urandom_range(0, 63) * 4), 1, 1'($urandom_range(0, 1)), 0, 0);
      tick();
    end
    drive(32'h0040_0104, 1, 32'h0, 0, 0, 0, 0);
    vectors++;
    if (32'(branch_cnt) !== b0 || 32'(mispredict_cnt) !== m_mcnt) begin
      miscompares++;
      $display("FAIL wrap_counts got=%0d/%0d exp=%0d/%0d", branch_cnt, mispredict_cnt, b0, m_mcnt);
    end
    tick();
    drive(32'h0040_0104, 1, 32'h0, 0, 0, 0, 0);
    rst = 1'b1;
    m_reset();
    #1;
    vectors++;
    if (pred_takenF !== 1'b0 || pred_takenD !== 1'b0 || branch_cnt !== 4'd0 || mispredict_cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL async_reset got=%b/%b/%0d/%0d exp=0/0/0/0", pred_takenF, pred_takenD, branch_cnt, mispredict_cnt);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] fpc, dpc;
    for (int n = 0; n < 400; n++) begin
      fpc = 32'h0040_0000 + 32'($urandom_range(0, 7) * 4) + ($urandom_range(0, 3) == 0 ? 32'h100 : 32'h0);
      dpc = 32'h0040_0000 + 32'($urandom_range(0, 7) * 4) + ($urandom_range(0, 3) == 0 ? 32'h100 : 32'h0);
      if ($urandom_range(0, 3) == 0) dpc = fpc;
      rst = ($urandom_range(0, 99) == 0);
      if (rst) m_reset();
      drive(fpc, 1'($urandom_range(0, 1)), dpc, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      vectors++;
      if (pred_takenF !== m_predF() || pred_takenD !== m_pred || mispredictD !== m_misp()) begin
        miscompares++;
        $display("FAIL rand_pred[%0d] got=%b%b%b exp=%b%b%b", n, pred_takenF, pred_takenD, mispredictD,
                 m_predF(), m_pred, m_misp());
      end
      vectors++;
      if (32'(branch_cnt) !== m_bcnt || 32'(mispredict_cnt) !== m_mcnt) begin
        miscompares++;
        $display("FAIL rand_cnt[%0d] got=%0d/%0d exp=%0d/%0d", n, branch_cnt, mispredict_cnt, m_bcnt, m_mcnt);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    m_reset();
    #2;
    test_reset();
    test_train();
    test_hysteresis();
    test_stall_flush();
    test_collision();
    test_alias_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
